// File: rtl/mem_bus_controller_pkg.sv
// Shared types for the cache-to-MainMemory bus controller.
// Address layout: {page[PAGE_W-1:0], line[LINE_W-1:0]}. Only pages below the
// configured page count exist; anything above is answered with an error.
package mem_bus_controller_pkg;

    localparam int unsigned MEM_PAGES = 2;
    localparam int unsigned PAGE_W    = 2;
    localparam int unsigned LINE_W    = 8;
    localparam int unsigned ADDR_W    = PAGE_W + LINE_W;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned MESI_W    = 2;

    typedef logic [ADDR_W-1:0] Taddress;
    typedef logic [DATA_W-1:0] Tdata_sb;

    typedef enum logic [MESI_W-1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } Tmesi_state;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } Tbus_state;

    typedef struct packed {
        logic       write;
        Taddress    addr;
        Tdata_sb    wdata;
        Tmesi_state mesi;
    } Tbus_req;

    function automatic logic [PAGE_W-1:0] page_of(Taddress a);
        return a[ADDR_W-1 -: PAGE_W];
    endfunction

    function automatic logic page_valid(Taddress a, int unsigned n_pages);
        return 32'(page_of(a)) < n_pages;
    endfunction

endpackage

// File: rtl/mem_bus_controller_rr_arbiter.sv
// Round-robin arbiter for the bus controller.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req          request vector, one bit per requester
//   en           grant is being taken this cycle; advances the rr pointer
//   grant        one-hot grant (combinational, valid with grant_valid)
//   grant_idx    index of the granted requester
//   grant_valid  at least one request is pending
// The search starts at the rr pointer; after a taken grant the pointer moves to
// the requester just after the winner so each pending requester is served once
// per N_REQ grants.
module mem_bus_controller_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] rr_q, rr_d;
    int unsigned      cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_valid && req[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        grant = grant_valid ? (N_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        rr_d = rr_q;
        if (en && grant_valid) begin
            rr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Arbiter/sequencer between N_REQ cache controllers and the single MainMemory port.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   req_*           per-requester request (valid held until its resp_valid pulse),
//                   packed flat, requester g in slice g
//   resp_valid      one-cycle completion pulse per requester
//   resp_err        page out of range; resp_rdata/resp_mesi are 0 on error
//   resp_rdata/mesi read data (or the written data on a writeback)
//   mem_*           MainMemory port; read is registered, write commits on mem_we
// Transaction: IDLE (grant) -> ISSUE (drive memory) -> WAIT (capture) -> RESP.
// Errors skip the memory: IDLE -> RESP.
module mem_bus_controller
    import mem_bus_controller_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned N_PAGES = MEM_PAGES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    input  logic [N_REQ*MESI_W-1:0] req_mesi,
    output logic [N_REQ-1:0]        resp_valid,
    output logic                    resp_err,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic [MESI_W-1:0]       resp_mesi,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [MESI_W-1:0]       mem_mesi_in,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic [MESI_W-1:0]       mem_mesi_out
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    Tbus_state        state_q, state_d;
    Tbus_req          req_arr [N_REQ];
    Tbus_req          gnt_req;
    logic [N_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             gnt_ok;

    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MESI_W-1:0] mem_mesi_q, mem_mesi_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [MESI_W-1:0] resp_mesi_q, resp_mesi_d;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_arr[g] = '{
            write: req_write[g],
            addr:  req_addr[g*ADDR_W +: ADDR_W],
            wdata: req_wdata[g*DATA_W +: DATA_W],
            mesi:  Tmesi_state'(req_mesi[g*MESI_W +: MESI_W])
        };
    end

    mem_bus_controller_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid),
        .en         (state_q == IDLE),
        .grant      (gnt_onehot),
        .grant_idx  (gnt_idx),
        .grant_valid(gnt_valid)
    );

    assign gnt_req = req_arr[gnt_idx];
    assign gnt_ok  = page_valid(gnt_req.addr, N_PAGES);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_valid) state_d = gnt_ok ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and latched request
    always_comb begin
        gidx_d       = gidx_q;
        wr_d         = wr_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        mem_mesi_d   = mem_mesi_q;
        resp_valid_d = '0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        resp_mesi_d  = resp_mesi_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gidx_d = gnt_idx;
                    wr_d   = gnt_req.write;
                    if (gnt_ok) begin
                        mem_addr_d  = gnt_req.addr;
                        mem_we_d    = gnt_req.write;
                        mem_wdata_d = gnt_req.wdata;
                        mem_mesi_d  = gnt_req.mesi;
                    end else begin
                        resp_valid_d = gnt_onehot;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        resp_mesi_d  = '0;
                    end
                end
            end
            WAIT: begin
                resp_valid_d = N_REQ'(1) << gidx_q;
                resp_err_d   = 1'b0;
                // A writeback reports back what it stored; mem_wdata/mesi still hold it.
                resp_rdata_d = wr_q ? mem_wdata_q : mem_rdata;
                resp_mesi_d  = wr_q ? mem_mesi_q : mem_mesi_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gidx_q       <= '0;
            wr_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            mem_mesi_q   <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_mesi_q  <= '0;
        end else begin
            gidx_q       <= gidx_d;
            wr_q         <= wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mesi_q   <= mem_mesi_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mesi_q  <= resp_mesi_d;
        end
    end

    // Gating with reset keeps a write whose commit edge coincides with reset
    // from reaching the memory.
    assign mem_we      = mem_we_q & ~reset;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_mesi_in = mem_mesi_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_mesi   = resp_mesi_q;

    // A granted requester must keep req_valid up while its access is in flight.
    req_held_a: assert property (@(posedge clk) disable iff (reset)
        (state_q inside {ISSUE, WAIT}) |-> req_valid[gidx_q]);

endmodule

// File: tb/tb_mem_bus_controller.sv
module tb_mem_bus_controller;
    import mem_bus_controller_pkg::*;

    localparam int NR        = 2;
    localparam int NP        = MEM_PAGES;
    localparam int MEM_DEPTH = 512;

    typedef struct packed {
        logic        write;
        logic [9:0]  addr;
        logic [63:0] wdata;
        logic [1:0]  mesi;
    } op_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [63:0] rdata;
        logic [1:0]  mesi;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*10-1:0] req_addr = '0;
    logic [NR*64-1:0] req_wdata = '0;
    logic [NR*2-1:0]  req_mesi = '0;
    logic [NR-1:0]    resp_valid;
    logic             resp_err;
    logic [63:0]      resp_rdata;
    logic [1:0]       resp_mesi;
    logic [9:0]       mem_addr;
    logic             mem_we;
    logic [63:0]      mem_wdata;
    logic [1:0]       mem_mesi_in;
    logic [63:0]      mem_rdata = '0;
    logic [1:0]       mem_mesi_out = '0;

    mem_bus_controller #(
        .N_REQ  (NR),
        .N_PAGES(NP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_mesi    (req_mesi),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .resp_mesi   (resp_mesi),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_mesi_in (mem_mesi_in),
        .mem_rdata   (mem_rdata),
        .mem_mesi_out(mem_mesi_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int midx(input logic [9:0] a);
        return int'({a[8], a[7:0]});
    endfunction

    function automatic logic [63:0] preload_data(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0000_0001_0001_0003;
    endfunction

    function automatic logic [1:0] preload_mesi(input int i);
        return 2'(i % 4);
    endfunction

    // MainMemory: registered read, write commits at the edge where mem_we is high.
    logic [63:0] env_data [MEM_DEPTH];
    logic [1:0]  env_mesi [MEM_DEPTH];
    int          we_count = 0;
    int          we_cyc   = -1;

    always @(posedge clk) begin
        if (mem_we) begin
            env_data[midx(mem_addr)] <= mem_wdata;
            env_mesi[midx(mem_addr)] <= mem_mesi_in;
            we_count <= we_count + 1;
            we_cyc   <= cyc;
        end
        mem_rdata    <= env_data[midx(mem_addr)];
        mem_mesi_out <= env_mesi[midx(mem_addr)];
    end

    // Reference model state
    logic [63:0] ref_data [MEM_DEPTH];
    logic [1:0]  ref_mesi [MEM_DEPTH];
    int          m_rr         = 0;
    int          exp_writes   = 0;
    logic [9:0]  exp_mem_addr = '0;
    exp_t        exp_q [$];
    op_t         ops [NR][$];
    int          dptr [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Transaction-level prediction: whenever the bus frees up, the first pending
    // requester at or after the rr pointer is served; 4 cycles per access,
    // 2 per error, response 3 (or 1) cycles after the grant cycle.
    function automatic void predict(input int start);
        int   t;
        int   mp [NR];
        bit   found;
        int   sel;
        int   c;
        op_t  op;
        exp_t e;
        t = start;
        sel = 0;
        for (int k = 0; k < NR; k++) mp[k] = 0;
        do begin
            found = 0;
            for (int k = 0; k < NR; k++) begin
                c = (m_rr + k) % NR;
                if (!found && mp[c] < ops[c].size()) begin
                    found = 1;
                    sel = c;
                end
            end
            if (found) begin
                op = ops[sel][mp[sel]];
                mp[sel]++;
                e.idx = sel;
                if (int'(op.addr[9:8]) >= NP) begin
                    e.err = 1'b1; e.rdata = '0; e.mesi = '0; e.cyc = t + 1;
                    t = t + 2;
                end else begin
                    e.err = 1'b0; e.cyc = t + 3;
                    exp_mem_addr = op.addr;
                    if (op.write) begin
                        ref_data[midx(op.addr)] = op.wdata;
                        ref_mesi[midx(op.addr)] = op.mesi;
                        exp_writes++;
                    end
                    e.rdata = ref_data[midx(op.addr)];
                    e.mesi  = ref_mesi[midx(op.addr)];
                    t = t + 4;
                end
                exp_q.push_back(e);
                m_rr = (sel + 1) % NR;
            end
        end while (found);
    endfunction

    task automatic drive(input int i);
        op_t op;
        if (dptr[i] < ops[i].size()) begin
            op = ops[i][dptr[i]];
            req_valid[i]            = 1'b1;
            req_write[i]            = op.write;
            req_addr[i*10 +: 10]    = op.addr;
            req_wdata[i*64 +: 64]   = op.wdata;
            req_mesi[i*2 +: 2]      = op.mesi;
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic add_op(input int i, input logic wr, input int page, input int line,
                          input logic [63:0] data, input logic [1:0] mesi);
        op_t op;
        op.write = wr;
        op.addr  = {2'(page), 8'(line)};
        op.wdata = data;
        op.mesi  = mesi;
        ops[i].push_back(op);
    endtask

    task automatic clear_ops();
        for (int i = 0; i < NR; i++) ops[i].delete();
    endtask

    // Starts every requester's op list in the same cycle; a requester re-raises
    // its next op in the cycle of its own response.
    task automatic run_batch(output int start);
        int budget;
        @(negedge clk);
        start = cyc;
        predict(start);
        for (int i = 0; i < NR; i++) begin
            dptr[i] = 0;
            drive(i);
        end
        budget = 200;
        while (req_valid != '0) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (resp_valid[i]) begin
                    dptr[i]++;
                    drive(i);
                end
            end
            budget--;
            if (budget == 0 && req_valid != '0) begin
                n_checks++;
                n_fail++;
                $display("FAIL batch_timeout: req_valid=0b%b still pending, required all served",
                         req_valid);
                req_valid = '0;
                exp_q.delete();
            end
        end
        chk("mem_we_count", 64'(we_count), 64'(exp_writes));
        chk("mem_addr_hold", 64'(mem_addr), 64'(exp_mem_addr));
        clear_ops();
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: resp_valid=0b%b at cycle %0d, required none",
                         resp_valid, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("resp_valid_bits", 64'(resp_valid), 64'(NR'(1) << e.idx));
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_err", 64'(resp_err), 64'(e.err));
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_mesi", 64'(resp_mesi), 64'(e.mesi));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            env_data[i] = preload_data(i);
            env_mesi[i] = preload_mesi(i);
            ref_data[i] = preload_data(i);
            ref_mesi[i] = preload_mesi(i);
        end

        // 1. Reset state, then a writeback
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_err", 64'(resp_err), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_mesi", 64'(resp_mesi), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_we", 64'(mem_we), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_mesi_in", 64'(mem_mesi_in), 0);
        reset = 1'b0;
        m_rr = 0;
        add_op(0, 1'b1, 0, 8'h10, 64'hDEADBEEF_00000001, 2'd3);
        run_batch(start);
        chk("t1_we_cycle", 64'(we_cyc), 64'(start + 1));

        // 2. Read back from the other requester
        add_op(1, 1'b0, 0, 8'h10, '0, '0);
        run_batch(start);

        // 3. Simultaneous reads, twice
        add_op(0, 1'b0, 0, 8'h01, '0, '0);
        add_op(1, 1'b0, 0, 8'h02, '0, '0);
        run_batch(start);
        add_op(0, 1'b0, 0, 8'h01, '0, '0);
        add_op(1, 1'b0, 0, 8'h02, '0, '0);
        run_batch(start);

        // 4. Page out of range
        add_op(0, 1'b0, 2, 8'h00, '0, '0);
        run_batch(start);

        // 5. Reset during the ISSUE cycle of a write
        @(negedge clk);
        ops[1].push_back('{write: 1'b1, addr: {2'd1, 8'hFF}, wdata: 64'h1111_2222_3333_4444,
                           mesi: 2'd3});
        dptr[1] = 0;
        drive(1);
        @(negedge clk);
        chk("t5_we_in_issue", 64'(mem_we), 1);
        reset = 1'b1;
        req_valid = '0;
        #1;
        chk("t5_we_gated", 64'(mem_we), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_ops();
        m_rr = 0;
        exp_mem_addr = '0;
        chk("t5_post_rst_we", 64'(mem_we), 0);
        chk("t5_post_rst_valid", 64'(resp_valid), 0);
        chk("t5_post_rst_addr", 64'(mem_addr), 0);
        repeat (5) @(negedge clk);
        chk("t5_no_commit", 64'(we_count), 64'(exp_writes));
        add_op(1, 1'b0, 1, 8'hFF, '0, '0);
        run_batch(start);

        // 6. Back-to-back with a competing reader
        add_op(0, 1'b1, 1, 8'h00, 64'h0123_4567_89AB_CDEF, 2'd2);
        add_op(0, 1'b0, 1, 8'h00, '0, '0);
        add_op(1, 1'b0, 0, 8'h00, '0, '0);
        add_op(1, 1'b0, 0, 8'h00, '0, '0);
        run_batch(start);

        // Random batches over a small address set to force line reuse
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < NR; i++) begin
                int n;
                n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) begin
                    int pg;
                    pg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3))
                                                     : int'($urandom_range(0, 1));
                    add_op(i, 1'($urandom_range(0, 1)), pg, int'($urandom_range(0, 3)),
                           {$urandom, $urandom}, 2'($urandom_range(0, 3)));
                end
            end
            run_batch(start);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
